// File: rtl/ram_writer_if.sv
// ram_writer_if
// Bundles the streaming input and the AXI4 master bus used by ram_writer.
//   AXIS_IN_*  : source data stream (TDATA/TVALID into the writer, TREADY out)
//   M_AXI_AW*  : write-address channel (writer drives, AWREADY returns)
//   M_AXI_W*   : write-data channel (writer drives, WREADY returns)
//   M_AXI_B*   : write-response channel (BRESP/BVALID return, BREADY driven)
//   M_AXI_AR*, M_AXI_RREADY : read side, held at zero by the writer
// Modports: master = ram_writer side, slave = memory / stream source side.
interface ram_writer_if #(
  parameter int DW = 512,
  parameter int IW = 5
);
  // Source stream
  logic [DW-1:0]   AXIS_IN_TDATA;
  logic            AXIS_IN_TVALID;
  logic            AXIS_IN_TREADY;

  // Write address channel
  logic [IW-1:0]   M_AXI_AWID;
  logic [63:0]     M_AXI_AWADDR;
  logic [7:0]      M_AXI_AWLEN;
  logic [2:0]      M_AXI_AWSIZE;
  logic [1:0]      M_AXI_AWBURST;
  logic            M_AXI_AWLOCK;
  logic [3:0]      M_AXI_AWCACHE;
  logic [2:0]      M_AXI_AWPROT;
  logic [3:0]      M_AXI_AWQOS;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;

  // Write data channel
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WLAST;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;

  // Write response channel
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;

  // Read address channel and read-data ready (unused, tied off)
  logic [IW-1:0]   M_AXI_ARID;
  logic [63:0]     M_AXI_ARADDR;
  logic [7:0]      M_AXI_ARLEN;
  logic [2:0]      M_AXI_ARSIZE;
  logic [1:0]      M_AXI_ARBURST;
  logic            M_AXI_ARLOCK;
  logic [3:0]      M_AXI_ARCACHE;
  logic [2:0]      M_AXI_ARPROT;
  logic [3:0]      M_AXI_ARQOS;
  logic            M_AXI_ARVALID;
  logic            M_AXI_RREADY;

  modport master (
    input  AXIS_IN_TDATA, AXIS_IN_TVALID,
    output AXIS_IN_TREADY,
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
           M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
           M_AXI_RREADY
  );

  modport slave (
    output AXIS_IN_TDATA, AXIS_IN_TVALID,
    input  AXIS_IN_TREADY,
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
           M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
           M_AXI_RREADY
  );
endinterface

// File: rtl/ram_writer.sv
// ram_writer
// Streams AXIS beats into memory starting at address 0 as a sequence of
// AXI4 INCR write bursts: full_blocks bursts of BLOCK_CYCLES beats followed
// by an optional trailing burst of partial_block_cycles beats.
// Ports:
//   clk                  : rising-edge clock
//   reset                : asynchronous active-high reset
//   full_blocks          : number of full blocks, captured on an accepted start
//   partial_block_cycles : beats in the trailing partial block (0 = none)
//   start                : one-cycle pulse, only honoured while idle
//   idle                 : no transfer in progress
//   bresp_error          : sticky, set by any non-OKAY write response
//   axi                  : stream input and AXI4 master (ram_writer_if.master)
// The address issue (AW FSM) and the data path (W) run independently; W may
// run ahead of AW, and completion is judged from the B-response count.
module ram_writer #(
  parameter int DW           = 512,
  parameter int IW           = 5,
  parameter int BLOCK_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   full_blocks,
  input  logic [7:0]    partial_block_cycles,
  input  logic          start,
  output logic          idle,
  output logic          bresp_error,
  ram_writer_if.master  axi
);

  typedef enum logic [1:0] {
    IDLE,
    FULL,
    PARTIAL,
    WAIT_B
  } state_t;

  localparam logic [63:0] BLOCK_BYTES    = 64'(BLOCK_CYCLES * (DW / 8));
  localparam logic [7:0]  FULL_LEN       = 8'(BLOCK_CYCLES - 1);
  localparam logic [8:0]  FULL_LAST_BEAT = 9'(BLOCK_CYCLES - 1);
  localparam logic [2:0]  AXI_SIZE       = 3'($clog2(DW / 8));

  state_t       state_q, state_d;
  logic [63:0]  awaddr_q, awaddr_d;
  logic [7:0]   awlen_q, awlen_d;
  logic [31:0]  full_q, full_d;
  logic [7:0]   part_q, part_d;
  logic [31:0]  aw_cnt_q, aw_cnt_d;
  logic [32:0]  w_burst_q, w_burst_d;
  logic [8:0]   beat_q, beat_d;
  logic [32:0]  b_cnt_q, b_cnt_d;
  logic         bresp_err_q, bresp_err_d;

  logic         aw_valid;
  logic         b_ready;
  logic         aw_hs;
  logic         w_hs;
  logic         b_hs;
  logic         w_active;
  logic         w_last;
  logic [8:0]   last_beat;
  logic [32:0]  total_bursts;

  // Handshake and W-path decode. The partial burst contributes one extra
  // burst to the total only when its length is nonzero.
  always_comb begin
    total_bursts = {1'b0, full_q} + {32'd0, (part_q != 8'd0)};
    w_active     = (w_burst_q < total_bursts);
    last_beat    = (w_burst_q < {1'b0, full_q}) ? FULL_LAST_BEAT
                                                : ({1'b0, part_q} - 9'd1);
    w_last       = w_active && (beat_q == last_beat);
    aw_valid     = (state_q == FULL) || (state_q == PARTIAL);
    b_ready      = (state_q != IDLE);
    aw_hs        = aw_valid && axi.M_AXI_AWREADY;
    w_hs         = axi.AXIS_IN_TVALID && axi.M_AXI_WREADY && w_active;
    b_hs         = axi.M_AXI_BVALID && b_ready;
  end

  // Next-state logic. W and B counting is evaluated first so that an
  // accepted start, handled in the IDLE branch, overrides it with a clean
  // restart of every counter.
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    full_d      = full_q;
    part_d      = part_q;
    aw_cnt_d    = aw_cnt_q;
    w_burst_d   = w_burst_q;
    beat_d      = beat_q;
    b_cnt_d     = b_cnt_q;
    bresp_err_d = bresp_err_q;

    if (w_hs) begin
      if (w_last) begin
        beat_d    = 9'd0;
        w_burst_d = w_burst_q + 33'd1;
      end else begin
        beat_d    = beat_q + 9'd1;
      end
    end

    if (b_hs) begin
      b_cnt_d = b_cnt_q + 33'd1;
      if (axi.M_AXI_BRESP != 2'b00) begin
        bresp_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          full_d      = full_blocks;
          part_d      = partial_block_cycles;
          awaddr_d    = 64'd0;
          aw_cnt_d    = 32'd0;
          w_burst_d   = 33'd0;
          beat_d      = 9'd0;
          b_cnt_d     = 33'd0;
          bresp_err_d = 1'b0;
          if (full_blocks != 32'd0) begin
            awlen_d = FULL_LEN;
            state_d = FULL;
          end else if (partial_block_cycles != 8'd0) begin
            awlen_d = partial_block_cycles - 8'd1;
            state_d = PARTIAL;
          end
        end
      end

      FULL: begin
        if (aw_hs) begin
          awaddr_d = awaddr_q + BLOCK_BYTES;
          aw_cnt_d = aw_cnt_q + 32'd1;
          if (aw_cnt_q == (full_q - 32'd1)) begin
            if (part_q != 8'd0) begin
              awlen_d = part_q - 8'd1;
              state_d = PARTIAL;
            end else begin
              state_d = WAIT_B;
            end
          end
        end
      end

      PARTIAL: begin
        if (aw_hs) begin
          state_d = WAIT_B;
        end
      end

      WAIT_B: begin
        if (b_cnt_q == total_bursts) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      awaddr_q    <= 64'd0;
      awlen_q     <= 8'd0;
      full_q      <= 32'd0;
      part_q      <= 8'd0;
      aw_cnt_q    <= 32'd0;
      w_burst_q   <= 33'd0;
      beat_q      <= 9'd0;
      b_cnt_q     <= 33'd0;
      bresp_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      full_q      <= full_d;
      part_q      <= part_d;
      aw_cnt_q    <= aw_cnt_d;
      w_burst_q   <= w_burst_d;
      beat_q      <= beat_d;
      b_cnt_q     <= b_cnt_d;
      bresp_err_q <= bresp_err_d;
    end
  end

  // idle drops in the start cycle itself so software sees the acceptance
  // even when a zero-length request never leaves IDLE.
  assign idle        = (state_q == IDLE) && !start;
  assign bresp_error = bresp_err_q;

  assign axi.M_AXI_AWID    = {IW{1'b0}};
  assign axi.M_AXI_AWADDR  = awaddr_q;
  assign axi.M_AXI_AWLEN   = awlen_q;
  assign axi.M_AXI_AWSIZE  = AXI_SIZE;
  assign axi.M_AXI_AWBURST = 2'b01;
  assign axi.M_AXI_AWLOCK  = 1'b0;
  assign axi.M_AXI_AWCACHE = 4'd0;
  assign axi.M_AXI_AWPROT  = 3'd0;
  assign axi.M_AXI_AWQOS   = 4'd0;
  assign axi.M_AXI_AWVALID = aw_valid;

  assign axi.M_AXI_WDATA    = axi.AXIS_IN_TDATA;
  assign axi.M_AXI_WSTRB    = {(DW/8){1'b1}};
  assign axi.M_AXI_WLAST    = w_last;
  assign axi.M_AXI_WVALID   = axi.AXIS_IN_TVALID && w_active;
  assign axi.AXIS_IN_TREADY = axi.M_AXI_WREADY && w_active;

  assign axi.M_AXI_BREADY = b_ready;

  assign axi.M_AXI_ARID    = {IW{1'b0}};
  assign axi.M_AXI_ARADDR  = 64'd0;
  assign axi.M_AXI_ARLEN   = 8'd0;
  assign axi.M_AXI_ARSIZE  = 3'd0;
  assign axi.M_AXI_ARBURST = 2'd0;
  assign axi.M_AXI_ARLOCK  = 1'b0;
  assign axi.M_AXI_ARCACHE = 4'd0;
  assign axi.M_AXI_ARPROT  = 3'd0;
  assign axi.M_AXI_ARQOS   = 4'd0;
  assign axi.M_AXI_ARVALID = 1'b0;
  assign axi.M_AXI_RREADY  = 1'b0;

endmodule
